decoder_scan_ctrl: RTL and testbench
====================================

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 The block SHALL use parameter DWELL_W, default 4: width of the dwell input and dwell counter.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request a scan; sampled only in IDLE.
REQ-006 Port: first  input  6  first address of the scan range.
REQ-007 Port: last  input  6  last address of the scan range.
REQ-008 Port: dwell  input  DWELL_W  cycles per address minus one (0 = 1 cycle).
REQ-009 Port: cont  input  1  1 = continuous scan: wrap to first after last; 0 = single pass.
REQ-010 Port: stop  input  1  abort an active scan.
REQ-011 Port: busy  output  1  high while in RUN.
REQ-012 Port: done  output  1  one-cycle pulse on completion of a single pass.
REQ-013 Port: addr  output  6  current scan address.
REQ-014 Port: sel  output  64  one-hot decode of addr while in RUN, else all zero.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 SHALL latch first, last, dwell and cont, load addr=first, clear the dwell counter and enter RUN on the next edge.
REQ-017 start SHALL be ignored in RUN and DONE; input changes after acceptance SHALL NOT affect the scan in progress.
REQ-018 In RUN, each address SHALL be held for exactly dwell+1 cycles, after which addr increments by one modulo 64.
REQ-019 If first > last, the scan SHALL wrap 63 -> 0 and continue to last; first == last scans one address.
REQ-020 Addresses per pass SHALL be ((last - first) mod 64) + 1; RUN cycles per pass SHALL be that count times (dwell+1).
REQ-021 At the final cycle of address last with cont=0, the FSM SHALL enter DONE on the next edge.
REQ-022 At the final cycle of address last with cont=1, addr SHALL reload the latched first and RUN SHALL continue, with no done pulse.
REQ-023 DONE SHALL last exactly one cycle with done=1, busy=0 and sel=0, then return to IDLE.
REQ-024 stop=1 in RUN SHALL enter IDLE on the next edge with no done pulse, including on the final cycle of a pass.
REQ-025 stop SHALL have no effect in IDLE or DONE; in IDLE with start=1 and stop=1, start SHALL be accepted.
REQ-026 busy SHALL be 1 exactly when state is RUN.
REQ-027 sel SHALL equal the decoder output of addr gated by busy.
REQ-028 addr SHALL hold its last value in DONE and IDLE.
REQ-029 From start sampled at edge N, busy=1 and sel=1<<first SHALL hold from cycle N+1.

Reset
REQ-030 Reset SHALL force state IDLE, addr=0, dwell counter=0, busy=0, done=0 and sel=0, with priority over start and stop.
REQ-031 Reset asserted mid-scan SHALL abort the scan without a done pulse; the latched range SHALL NOT be reused.

Structure
REQ-032 Package decoder_scan_pkg SHALL hold the state enum typedef and constants ADDR_W=6 and N_OUT=64.
REQ-033 The block SHALL instantiate the existing decoder64 (ports a[5:0], y[63:0]) as its one sub-module to produce sel.

Verification
REQ-034 first=3, last=5, dwell=0, cont=0, start pulse -> sel one-hot on bits 3, 4, 5 for one cycle each, then done=1 for one cycle, busy=0.
REQ-035 first=62, last=1, dwell=1, cont=0 -> addr sequence 62,62,63,63,0,0,1,1 (8 cycles), then done.
REQ-036 first=10, last=11, dwell=0, cont=1 -> addr 10,11,10,11 repeating with no done; stop at addr 11 -> IDLE next cycle, sel=0, no done.
REQ-037 start held high through a scan with first/last changed mid-run -> no restart, original range completes, exactly one done.
REQ-038 Reset asserted at the second cycle of a dwell=3 scan -> next cycle all outputs at reset values; subsequent start runs normally.
REQ-039 A bench SHALL check every RUN cycle that sel is one-hot and equals 1<<addr, and that sel is zero outside RUN.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the address scan controller and its decoder.
package decoder_scan_pkg;

    localparam int ADDR_W = 6;
    localparam int N_OUT  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage : decoder_scan_pkg

// File: rtl/decoder64.sv
// 6-to-64 one-hot decoder used to drive the scan select lines.
module decoder64
    import decoder_scan_pkg::*;
(
    input  logic [ADDR_W-1:0] a,
    output logic [N_OUT-1:0]  y
);

    always_comb begin
        // NOTE: assigning a default before any conditional write keeps always_comb free of latches.
        y    = '0;
        y[a] = 1'b1;
    end

endmodule : decoder64

// File: rtl/decoder_scan_ctrl.sv
// Scans an address range (with wrap) holding each address for dwell+1 cycles,
// presenting the current address and its one-hot decode while running.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  first,
    input  logic [ADDR_W-1:0]  last,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               cont,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  addr,
    output logic [N_OUT-1:0]   sel
);

    scan_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]  first_q, first_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [N_OUT-1:0]   dec_y;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    first_d = first;
                    last_d  = last;
                    dwell_d = dwell;
                    cont_d  = cont;
                    addr_d  = first;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (addr_q != last_q) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end else if (cont_q) begin
                        addr_d = first_q;
                    end else begin
                        // Final address of a single pass: addr is kept for DONE/IDLE.
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
        end
    end

    decoder64 u_dec (
        .a (addr_q),
        .y (dec_y)
    );

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign addr = addr_q;
    assign sel  = busy ? dec_y : '0;

endmodule : decoder_scan_ctrl

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench: stimulus pushes expected per-cycle addresses and done events; a negedge monitor pops and compares.
module tb_decoder_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  first = '0;
    logic [5:0]  last = '0;
    logic [3:0]  dwell = '0;
    logic        cont = 1'b0;
    logic        stop = 1'b0;
    logic        busy, done;
    logic [5:0]  addr;
    logic [63:0] sel;

    typedef struct {
        bit          is_done;
        int unsigned a;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;

    int unsigned v34[3] = '{3, 4, 5};
    int unsigned v35[8] = '{62, 62, 63, 63, 0, 0, 1, 1};
    int unsigned v36[6] = '{10, 11, 10, 11, 10, 11};
    int unsigned v37[6] = '{30, 30, 31, 31, 32, 32};
    int unsigned v38[2] = '{20, 20};
    int unsigned v38b[2] = '{7, 8};

    decoder_scan_ctrl #(.DWELL_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .first (first),
        .last  (last),
        .dwell (dwell),
        .cont  (cont),
        .stop  (stop),
        .busy  (busy),
        .done  (done),
        .addr  (addr),
        .sel   (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int unsigned a);
        exp_t e;
        e.is_done = 1'b0;
        e.a       = a;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.a       = 0;
        exp_q.push_back(e);
    endtask

    task automatic launch(input logic [5:0] f, input logic [5:0] l, input logic [3:0] d, input logic c);
        first = f;
        last  = l;
        dwell = d;
        cont  = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            step();
            k++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: every cycle, compare whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy || done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got busy=%0b done=%0b addr=%0d expected idle at %0t",
                             busy, done, addr, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_done) begin
                        check("done_pulse", {62'd0, busy, done}, 64'd1);
                        check("done_sel", sel, 64'd0);
                    end else begin
                        check("run_addr", 64'(addr), 64'(e.a));
                        check("run_sel", sel, 64'd1 << e.a);
                        check("run_onehot", 64'($onehot(sel)), 64'd1);
                        check("run_done_low", 64'(done), 64'd0);
                    end
                end
            end else begin
                check("idle_sel", sel, 64'd0);
            end
        end
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_sel", sel, 64'd0);
        mon_en = 1'b1;
        step();

        // Simple single pass.
        foreach (v34[i]) push_a(v34[i]);
        push_done();
        launch(6'd3, 6'd5, 4'd0, 1'b0);
        wait_drain("t34", 20);
        repeat (2) step();
        check("t34_addr_hold", 64'(addr), 64'd5);

        // Range wrapping through 63 -> 0 with dwell 1.
        foreach (v35[i]) push_a(v35[i]);
        push_done();
        launch(6'd62, 6'd1, 4'd1, 1'b0);
        wait_drain("t35", 30);
        repeat (2) step();

        // Continuous scan, stopped on the last address of a pass.
        foreach (v36[i]) push_a(v36[i]);
        launch(6'd10, 6'd11, 4'd0, 1'b1);
        repeat (5) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t36_busy_after_stop", 64'(busy), 64'd0);
        check("t36_queue", 64'(exp_q.size()), 64'd0);
        repeat (3) step();

        // start held high, inputs changed mid-run: original range completes once.
        foreach (v37[i]) push_a(v37[i]);
        push_done();
        first = 6'd30; last = 6'd32; dwell = 4'd1; cont = 1'b0;
        start = 1'b1;
        step();
        first = 6'd0; last = 6'd63; dwell = 4'd5; cont = 1'b1;
        repeat (6) step();
        start = 1'b0;
        wait_drain("t37", 10);
        repeat (3) step();

        // Reset during the second cycle of a dwell=3 scan.
        foreach (v38[i]) push_a(v38[i]);
        launch(6'd20, 6'd22, 4'd3, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t38_busy", 64'(busy), 64'd0);
        check("t38_done", 64'(done), 64'd0);
        check("t38_addr", 64'(addr), 64'd0);
        check("t38_sel", sel, 64'd0);
        check("t38_queue", 64'(exp_q.size()), 64'd0);
        step();
        foreach (v38b[i]) push_a(v38b[i]);
        push_done();
        launch(6'd7, 6'd8, 4'd0, 1'b0);
        wait_drain("t38b", 10);
        repeat (3) step();

        // Single address; stop asserted together with start is ignored in IDLE.
        push_a(40);
        push_a(40);
        push_a(40);
        push_done();
        stop = 1'b1;
        launch(6'd40, 6'd40, 4'd2, 1'b0);
        stop = 1'b0;
        wait_drain("t_single", 10);
        repeat (3) step();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule : tb_decoder_scan_ctrl
